// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock/tick generator: counter width,
// standard divider rates from the 100 MHz system clock, and a channel-select width helper.
package clk_div_pkg;

   localparam int CNT_W_DEF      = 24;

   localparam int PERIOD_2MHZ    = 50;
   localparam int HIGH_2MHZ      = 25;
   localparam int PERIOD_1MHZ    = 100;
   localparam int HIGH_1MHZ      = 50;

   // Servo PWM: 20 ms frame, 1..2 ms pulse
   localparam int PERIOD_SERVO   = 2_000_000;
   localparam int HIGH_SERVO_MIN = 100_000;
   localparam int HIGH_SERVO_MAX = 200_000;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: free-running counter, active and shadow period/high registers,
// and the pending-config apply logic that only swaps settings at a period boundary.
module clk_div_ch #(
   parameter int CNT_W      = 24,
   parameter int DEF_PERIOD = 50,
   parameter int DEF_HIGH   = 25
) (
   input  logic             clk_int,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             accept,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             pending,
   output logic             clk_out,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high;
   logic [CNT_W-1:0] shadow_period;
   logic [CNT_W-1:0] shadow_high;
   logic             run;
   logic             wrap;
   logic             apply;

   always_comb begin
      run   = en && (period != '0);
      wrap  = run && (cnt == period - 1'b1);
      // Any point where the channel is not mid-period is a safe place to swap settings
      apply = pending && (wrap || !en || (period == '0) || sync);
   end

   always_ff @(posedge clk_int) begin
      if (rst) begin
         cnt     <= '0;
         period  <= CNT_W'(DEF_PERIOD);
         high    <= CNT_W'(DEF_HIGH);
         pending <= 1'b0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         clk_out <= run && (cnt < high);
         tick    <= wrap;
         if (!run || wrap || sync) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (apply) begin
            period  <= shadow_period;
            high    <= shadow_high;
            pending <= 1'b0;
         end else if (accept) begin
            pending <= 1'b1;
         end
      end
   end

   // Shadow copies are pure data; pending alone decides whether they are used
   always_ff @(posedge clk_int) begin
      if (accept) begin
         shadow_period <= cfg_period;
         shadow_high   <= cfg_high;
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator with a shared valid/ready config port
// and a common sync input that phase-aligns all channels.
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int DEF_PERIOD = PERIOD_2MHZ,
   parameter int DEF_HIGH   = HIGH_2MHZ,
   localparam int CH_W      = clog2_min1(NUM_CH)
) (
   input  logic              clk_int,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] accept;

   // Out-of-range channel selects are never ready, so they can never be accepted
   always_comb begin
      cfg_ready = 1'b0;
      accept    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = ~pending[i];
            accept[i] = cfg_valid && ~pending[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD),
         .DEF_HIGH   (DEF_HIGH)
      ) u_ch (
         .clk_int    (clk_int),
         .rst        (rst),
         .en         (en[g]),
         .sync       (sync),
         .accept     (accept[g]),
         .cfg_period (cfg_period),
         .cfg_high   (cfg_high),
         .pending    (pending[g]),
         .clk_out    (clk_out[g]),
         .tick       (tick[g])
      );
   end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock/tick generator; the successor to the fixed-ratio single-output divider in the radar hardware.
- Each channel has a runtime-programmable period and high time, giving arbitrary duty cycle, plus a one-cycle tick strobe per period.
- Feeds the ultrasonic trigger/echo timebase and the servo PWM from the 100 MHz system clock.
- New configurations apply only at period boundaries (glitch-free); a common sync input phase-aligns all channels.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 24, width of period/high/counter registers
DEF_PERIOD, 50, reset period in clk_int cycles (100 MHz -> 2 MHz)
DEF_HIGH, 25, reset high time in clk_int cycles (50 % duty)
CH_W, $clog2(NUM_CH) min 1, derived, width of channel select

Ports:
clk_int  in  1  system clock, 100 MHz, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  NUM_CH  per-channel run enable
sync  in  1  one-cycle pulse: restart all channel counters at 0
cfg_valid  in  1  config request
cfg_ready  out  1  config accept (handshake completes when valid && ready)
cfg_ch  in  CH_W  target channel
cfg_period  in  CNT_W  new period P (cycles)
cfg_high  in  CNT_W  new high time H (cycles)
clk_out  out  NUM_CH  divided clock per channel (registered)
tick  out  NUM_CH  one-cycle strobe per channel at end of period (registered)

Behaviour:
- Reset (rst=1 at a clk_int edge):
  - Every cnt=0; active P=DEF_PERIOD, H=DEF_HIGH.
  - pending=0; clk_out=0; tick=0; cfg_ready=1.
  - rst overrides all other inputs, including mid-period and mid-handshake; a pending config is discarded.
- Per channel, each cycle with en=1 and P>=1:
  - cnt <= (cnt==P-1) ? 0 : cnt+1.
  - clk_out <= (cnt < H).
  - tick <= (cnt == P-1).
  - clk_out and tick lag cnt by exactly one cycle.
  - Output period is P cycles with H cycles high. H>=P gives constant high; H=0 gives constant low.
- P=1: cnt stays 0, tick=1 every enabled cycle, clk_out=(H>=1).
- P=0: channel stopped; cnt held 0, clk_out<=0, tick<=0.
- en=0: cnt<=0, clk_out<=0, tick<=0. Re-enabling starts at cnt=0, so the first clk_out high appears 1 cycle after the en rise (when H>0).
- Config handshake:
  - cfg_ready = ~pending[cfg_ch] (combinational from the pending register and cfg_ch).
  - On accept: shadow_P/H[cfg_ch] <= cfg_period/cfg_high; pending[cfg_ch] <= 1.
  - One outstanding request per channel; requests to other channels are independent.
- Apply point: pending channel copies shadow into active P/H, clears pending, and sets cnt<=0 on the cycle where any of these holds:
  - (en && cnt==P-1), i.e. a wrap;
  - en==0;
  - P==0;
  - sync==1.
  - The tick for the finishing period is still emitted. The new P/H govern clk_out from the next cycle.
- sync: all enabled channels set cnt<=0 on that cycle; tick is NOT asserted for the truncated period. Pending configs apply.
  - sync coinciding with a natural wrap: behaves as the wrap, tick=1.
- Accept and apply in the same cycle for the same channel is impossible (ready is low while pending). After an apply, cfg_ready for that channel rises the following cycle.
- Arithmetic: unsigned CNT_W; comparisons unsigned; no overflow (cnt < P <= 2^CNT_W-1).

Decomposition:
- Shared package clk_div_pkg holds:
  - CNT_W default;
  - DEF_PERIOD/DEF_HIGH for the standard rates: 2 MHz=50/25, 1 MHz=100/50, servo 50 Hz=2_000_000 with high 100_000..200_000;
  - the clog2 helper.
- One sub-module, clk_div_ch: a single channel holding cnt, active/shadow registers, pending, and the apply logic.
- Top-level clk_div_multi contains the generate loop, cfg_ch decode, and the cfg_ready mux.

Test Plan:
- Reset, en=2'b11, no cfg -> both clk_out square, 50 cycles period, 25 high; tick every 50 cycles; first tick 50 cycles after en rises.
- cfg ch0 P=10 H=3 accepted mid-period (cnt=20) -> ch0 finishes the 50-cycle period with tick, then 10-cycle period, 3 high. cfg_ready(ch0) is low until the apply, while ch1 is unaffected.
- Second cfg to ch0 while pending -> cfg_ready=0, no state change. Simultaneous cfg to ch1 -> accepted.
- sync at cnt=30 on ch0 (P=50) -> cnt restarts, no tick, next tick 50 cycles later. sync on the wrap cycle -> tick=1 once.
- Edge values: P=1 H=1 -> tick and clk_out constant 1. P=0 -> both 0. H=0 -> clk_out 0 with tick each period. H=P=7 -> clk_out constant 1.
- rst asserted with a pending config and ch0 at cnt=5 -> next cycle all outputs 0, P=50/H=25 restored, cfg_ready=1, pending config lost.
